mem_access_ctrl: RTL

//  Multi-cycle load/store sequencer between the combinational execute stage and the system bus (sb).

---
 rtl/mem_access_ctrl_pkg.sv | 29 ++
 rtl/mem_access_ctrl_if.sv | 29 ++
 rtl/mem_access_ctrl_align.sv | 54 +++++
 rtl/mem_access_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the load/store sequencer: access sizes,
// FSM state codes and the alignment rule applied to incoming requests.
package mem_access_ctrl_pkg;

  localparam logic [1:0] SL_BYTE = 2'b00;
  localparam logic [1:0] SL_HALF = 2'b01;
  localparam logic [1:0] SL_WORD = 2'b10;

  localparam int STRB_WIDTH = 4;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_REQ  = 2'd1,
    MAC_RESP = 2'd2,
    MAC_DONE = 2'd3
  } mac_state_e;

  // The unused size code 2'b11 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SL_BYTE: mis = 1'b0;
      SL_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// System-bus port of the load/store sequencer, grouped so the controller and
// the bus model/fabric connect through one modport each.
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  // Handshake: the master raises bus_req_o and keeps we/addr/wdata/wstrb
  // stable until a cycle with bus_gnt_i=1, which accepts the request. For a
  // read, the word arrives in a later cycle flagged by bus_rvalid_i. gnt and
  // rvalid seen while no request is outstanding carry no meaning.
  logic                  bus_req_o;
  logic                  bus_we_o;
  logic [31:0]           bus_addr_o;
  logic [31:0]           bus_wdata_o;
  logic [STRB_WIDTH-1:0] bus_wstrb_o;
  logic                  bus_gnt_i;
  logic                  bus_rvalid_i;
  logic [31:0]           bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wstrb_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

endinterface

// File: rtl/mem_access_ctrl_align.sv
// Combinational data alignment: store lane replication and byte strobes,
// and load-word shift with zero/sign extension.
module mem_access_ctrl_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]            st_size_i,
  input  logic [1:0]            st_addr_lo_i,
  input  logic [31:0]           st_data_i,
  output logic [31:0]           st_wdata_o,
  output logic [STRB_WIDTH-1:0] st_wstrb_o,
  input  logic [1:0]            ld_size_i,
  input  logic [1:0]            ld_addr_lo_i,
  input  logic                  ld_unsigned_i,
  input  logic [31:0]           ld_rdata_i,
  output logic [31:0]           ld_data_o
);

  logic [31:0] ld_shifted;
  logic        ld_sign;

  always_comb begin
    st_wdata_o = st_data_i;
    st_wstrb_o = 4'b1111;
    case (st_size_i)
      SL_BYTE: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_wstrb_o = 4'b0001 << st_addr_lo_i;
      end
      SL_HALF: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_wstrb_o = 4'b0011 << {st_addr_lo_i[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_addr_lo_i, 3'b000};
    ld_sign    = 1'b0;
    ld_data_o  = ld_shifted;
    case (ld_size_i)
      SL_BYTE: begin
        ld_sign   = ~ld_unsigned_i & ld_shifted[7];
        ld_data_o = {{24{ld_sign}}, ld_shifted[7:0]};
      end
      SL_HALF: begin
        ld_sign   = ~ld_unsigned_i & ld_shifted[15];
        ld_data_o = {{16{ld_sign}}, ld_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer: latches one request from execute, stalls
// the pipeline while it runs the bus handshake, and writes back load data.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_re_i,
  input  logic                     mem_we_i,
  input  logic [31:0]              mem_raddr_i,
  input  logic [31:0]              mem_waddr_i,
  input  logic [31:0]              mem_wdata_i,
  input  logic [1:0]               byte_sel_i,
  input  logic                     un_sign_i,
  input  logic [4:0]               rd_waddr_i,
  mem_access_ctrl_if.master        sb,
  output logic                     hold_o,
  output logic                     ld_we_o,
  output logic [4:0]               ld_waddr_o,
  output logic [31:0]              ld_wdata_o,
  output logic                     misalign_o,
  output logic                     bus_err_o,
  output mac_state_e               state_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mac_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [4:0]            rd_q, rd_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  ld_we_q, ld_we_d;
  logic [4:0]            ld_waddr_q, ld_waddr_d;
  logic [31:0]           ld_wdata_q, ld_wdata_d;
  logic                  misalign_q, misalign_d;
  logic                  bus_err_q, bus_err_d;

  logic                  req_valid;
  logic [31:0]           req_addr;
  logic                  req_mis;
  logic                  timeout_hit;
  logic [31:0]           st_wdata;
  logic [STRB_WIDTH-1:0] st_wstrb;
  logic [31:0]           ld_data;

  // A store wins when execute raises both enables.
  assign req_valid   = mem_re_i | mem_we_i;
  assign req_addr    = mem_we_i ? mem_waddr_i : mem_raddr_i;
  assign req_mis     = is_misaligned(byte_sel_i, req_addr[1:0]);
  assign timeout_hit = (cnt_q == CNT_LAST);

  mem_access_ctrl_align u_align (
    .st_size_i     (byte_sel_i),
    .st_addr_lo_i  (req_addr[1:0]),
    .st_data_i     (mem_wdata_i),
    .st_wdata_o    (st_wdata),
    .st_wstrb_o    (st_wstrb),
    .ld_size_i     (size_q),
    .ld_addr_lo_i  (addr_q[1:0]),
    .ld_unsigned_i (uns_q),
    .ld_rdata_i    (sb.bus_rdata_i),
    .ld_data_o     (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MAC_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      ld_we_q    <= 1'b0;
      ld_waddr_q <= '0;
      ld_wdata_q <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      ld_we_q    <= ld_we_d;
      ld_waddr_q <= ld_waddr_d;
      ld_wdata_q <= ld_wdata_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    ld_we_d    = 1'b0;
    ld_waddr_d = ld_waddr_q;
    ld_wdata_d = ld_wdata_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    hold_o     = 1'b0;

    case (state_q)
      MAC_IDLE: begin
        if (req_valid) begin
          if (req_mis) begin
            misalign_d = 1'b1;
          end else begin
            hold_o  = 1'b1;
            cnt_d   = '0;
            we_d    = mem_we_i;
            addr_d  = req_addr;
            size_d  = byte_sel_i;
            uns_d   = un_sign_i;
            rd_d    = rd_waddr_i;
            wdata_d = mem_we_i ? st_wdata : '0;
            wstrb_d = mem_we_i ? st_wstrb : '0;
            state_d = MAC_REQ;
          end
        end
      end
      MAC_REQ: begin
        hold_o = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (sb.bus_gnt_i) begin
          state_d = we_q ? MAC_DONE : MAC_RESP;
        end else if (timeout_hit) begin
          state_d   = MAC_DONE;
          bus_err_d = 1'b1;
        end
      end
      MAC_RESP: begin
        hold_o = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (sb.bus_rvalid_i) begin
          ld_we_d    = 1'b1;
          ld_waddr_d = rd_q;
          ld_wdata_d = ld_data;
          state_d    = MAC_DONE;
        end else if (timeout_hit) begin
          state_d   = MAC_DONE;
          bus_err_d = 1'b1;
        end
      end
      // Execute still shows the finished request here; it is deliberately dropped.
      MAC_DONE: state_d = MAC_IDLE;
      default:  state_d = MAC_IDLE;
    endcase
  end

  assign sb.bus_req_o   = (state_q == MAC_REQ);
  assign sb.bus_we_o    = we_q;
  assign sb.bus_addr_o  = {addr_q[31:2], 2'b00};
  assign sb.bus_wdata_o = wdata_q;
  assign sb.bus_wstrb_o = wstrb_q;

  assign ld_we_o    = ld_we_q;
  assign ld_waddr_o = ld_waddr_q;
  assign ld_wdata_o = ld_wdata_q;
  assign misalign_o = misalign_q;
  assign bus_err_o  = bus_err_q;
  assign state_o    = state_q;

endmodule
